// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Memory waits are bounded by MEM_TIMEOUT; a missing ack or an illegal opcode
// halts the sequencer in TRAP until trap_clr.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   run                  level; permits starting a new instruction
//   imem_ack, dmem_ack   memory acks (ignored outside FETCH/MEM)
//   dec_*                decoder controls for the instruction held in IR
//   trap_clr             pulse; releases TRAP
//   imem_req, ir_we, dmem_req, dmem_we, gp_we, pc_we   datapath strobes
//   pc_sel               latched PC-source select
//   trap, trap_cause     halted flag and cause (01 illegal, 10 imem, 11 dmem)
//   state                encoded state (IDLE=0 .. TRAP=6)
//   retired              count of completed instructions (wraps)
module exec_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        dec_gp_we,
  input  logic        dec_mem_wren,
  input  logic        dec_mem_rren,
  input  logic        dec_illegal,
  input  logic [1:0]  dec_pc_sel,
  input  logic        trap_clr,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        gp_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [7:0] Timeout = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        gp_we_q, gp_we_d;
  logic        wren_q, wren_d;
  logic        rren_q, rren_d;
  logic [1:0]  pc_sel_q, pc_sel_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      gp_we_q   <= 1'b0;
      wren_q    <= 1'b0;
      rren_q    <= 1'b0;
      pc_sel_q  <= 2'b00;
      cause_q   <= 2'b00;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      gp_we_q   <= gp_we_d;
      wren_q    <= wren_d;
      rren_q    <= rren_d;
      pc_sel_q  <= pc_sel_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gp_we_d   = gp_we_q;
    wren_d    = wren_q;
    rren_d    = rren_q;
    pc_sel_d  = pc_sel_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          wait_d  = 8'd0;
        end
      end
      StFetch: begin
        // An ack arriving on the timeout cycle still completes the fetch.
        if (imem_ack) begin
          state_d = StDecode;
        end else if (wait_q == Timeout) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        gp_we_d  = dec_gp_we;
        wren_d   = dec_mem_wren;
        rren_d   = dec_mem_rren;
        pc_sel_d = dec_pc_sel;
        if (dec_illegal) begin
          state_d = StTrap;
          cause_d = 2'b01;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (wren_q || rren_q) begin
          state_d = StMem;
          wait_d  = 8'd0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          state_d = StWb;
        end else if (wait_q == Timeout) begin
          state_d = StTrap;
          cause_d = 2'b11;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        retired_d = retired_q + 32'd1;
        if (run) begin
          state_d = StFetch;
          wait_d  = 8'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StTrap: begin
        if (trap_clr) begin
          state_d = StIdle;
          cause_d = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == StFetch);
    ir_we      = (state_q == StFetch) && imem_ack;
    dmem_req   = (state_q == StMem);
    // Write wins when both wren and rren are latched.
    dmem_we    = (state_q == StMem) && wren_q;
    gp_we      = (state_q == StWb) && gp_we_q;
    pc_we      = (state_q == StWb);
    pc_sel     = pc_sel_q;
    trap       = (state_q == StTrap);
    trap_cause = cause_q;
    state      = state_q;
    retired    = retired_q;
  end

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  localparam int unsigned Tmo = 15;

  logic        clk, rst_n, run, imem_ack, dmem_ack;
  logic        dec_gp_we, dec_mem_wren, dec_mem_rren, dec_illegal, trap_clr;
  logic [1:0]  dec_pc_sel;
  logic        imem_req, ir_we, dmem_req, dmem_we, gp_we, pc_we, trap;
  logic [1:0]  pc_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] retired;

  exec_sequencer #(.MEM_TIMEOUT(Tmo)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .dec_gp_we    (dec_gp_we),
    .dec_mem_wren (dec_mem_wren),
    .dec_mem_rren (dec_mem_rren),
    .dec_illegal  (dec_illegal),
    .dec_pc_sel   (dec_pc_sel),
    .trap_clr     (trap_clr),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .gp_we        (gp_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gp;
    logic [1:0]  sel;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_ret = 32'd0;
  logic [31:0] ret_exp;
  logic        ret_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: each WB pulse pops one expected instruction.
  always @(negedge clk) begin
    if (ret_pending) begin
      check("retired", retired, ret_exp);
      ret_pending = 1'b0;
    end
    if (pc_we) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'(pc_we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_gp_we", 32'(gp_we), 32'(e.gp));
        check("wb_pc_sel", 32'(pc_sel), 32'(e.sel));
        ret_exp     = e.ret;
        ret_pending = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    rst_n = 1'b1;
    model_ret = 32'd0;
    tick();
  endtask

  task automatic clear_trap(input logic [1:0] cause);
    check("trap_state", 32'(state), 32'd6);
    check("trap_flag", 32'(trap), 32'd1);
    check("trap_cause", 32'(trap_cause), 32'(cause));
    check("trap_strobes", 32'({imem_req, dmem_req, gp_we, pc_we}), 32'd0);
    check("trap_retired", retired, model_ret);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_cause", 32'(trap_cause), 32'd0);
  endtask

  // Runs one instruction from IDLE; iw/dw are ack delays in wait cycles,
  // values above Tmo mean the ack never arrives.
  task automatic do_instr(input logic gp, input logic wr, input logic rr, input logic ill,
                          input logic [1:0] sel, input int iw, input int dw,
                          input logic keep_run);
    int   waits;
    exp_t e;
    dec_gp_we = gp; dec_mem_wren = wr; dec_mem_rren = rr;
    dec_illegal = ill; dec_pc_sel = sel;
    run = 1'b1; imem_ack = 1'b0;
    tick();
    run = keep_run;
    check("fetch_entry", 32'(state), 32'd1);
    waits = 0;
    while (waits < iw && waits <= int'(Tmo)) begin
      check("fetch_hold", 32'(state), 32'd1);
      check("imem_req", 32'(imem_req), 32'd1);
      check("ir_we_idle", 32'(ir_we), 32'd0);
      tick();
      waits++;
    end
    if (iw > int'(Tmo)) begin
      clear_trap(2'b10);
      return;
    end
    imem_ack = 1'b1;
    #1;
    check("ir_we", 32'(ir_we), 32'd1);
    if (!ill && (!(wr || rr) || dw <= int'(Tmo))) begin
      model_ret = model_ret + 32'd1;
      e.gp = gp; e.sel = sel; e.ret = model_ret;
      sb.push_back(e);
    end
    tick();
    imem_ack = 1'b0;
    check("decode", 32'(state), 32'd2);
    tick();
    if (ill) begin
      clear_trap(2'b01);
      return;
    end
    check("exec", 32'(state), 32'd3);
    check("exec_pc_we", 32'(pc_we), 32'd0);
    tick();
    if (wr || rr) begin
      dmem_ack = 1'b0;
      waits = 0;
      while (waits < dw && waits <= int'(Tmo)) begin
        check("mem_hold", 32'(state), 32'd4);
        check("dmem_req", 32'(dmem_req), 32'd1);
        check("dmem_we", 32'(dmem_we), 32'(wr));
        tick();
        waits++;
      end
      if (dw > int'(Tmo)) begin
        clear_trap(2'b11);
        return;
      end
      dmem_ack = 1'b1;
      check("mem_last", 32'(state), 32'd4);
      check("dmem_we_ack", 32'(dmem_we), 32'(wr));
      tick();
      dmem_ack = 1'b0;
    end
    check("wb", 32'(state), 32'd5);
    check("wb_pc_we", 32'(pc_we), 32'd1);
    tick();
    check("wb_exit", 32'(state), keep_run ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
    dec_gp_we = 1'b0; dec_mem_wren = 1'b0; dec_mem_rren = 1'b0;
    dec_illegal = 1'b0; dec_pc_sel = 2'b00;
    #3;
    check("init_state", 32'(state), 32'd0);
    check("init_trap", 32'({trap, trap_cause}), 32'd0);
    check("init_retired", retired, 32'd0);
    check("init_strobes", 32'({imem_req, dmem_req, gp_we, pc_we}), 32'd0);
    #4;
    rst_n = 1'b1;
    tick();

    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);        // ALU op
    do_instr(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 0, 3, 1'b0);        // lw, ack after 3
    do_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2, 1, 1'b0);        // wren+rren -> write
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, int'(Tmo), 0, 1'b0); // ack on timeout cycle
    do_instr(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1, int'(Tmo), 1'b0); // dmem ack on timeout
    do_instr(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 0, 0, 1'b0);        // illegal
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, int'(Tmo) + 1, 0, 1'b0); // imem timeout
    do_instr(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 0, int'(Tmo) + 1, 1'b0); // dmem timeout
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1, 0, 1'b1);        // run held -> FETCH
    do_reset();                                                 // reset lands mid-FETCH

    // Reset during MEM: request drops before the next edge, no WB.
    dec_gp_we = 1'b1; dec_mem_wren = 1'b0; dec_mem_rren = 1'b1; dec_illegal = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    check("mem_pre_rst", 32'(dmem_req), 32'd1);
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mem_rst_req", 32'(dmem_req), 32'd0);
    check("mem_rst_state", 32'(state), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("mem_rst_idle", 32'(state), 32'd0);
    check("mem_rst_ret", retired, 32'd0);

    // Wrap of the retired counter.
    do_reset();
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    #1;
    check("preload", retired, 32'hFFFF_FFFF);
    model_ret = 32'hFFFF_FFFF;
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("wrap", retired, 32'd0);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15: max wait cycles for a memory ack, range 1..255.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port run  input  1  level; permits starting a new instruction.
REQ-005 The block SHALL have port imem_ack  input  1  instruction memory ack for the current fetch.
REQ-006 The block SHALL have port dmem_ack  input  1  data memory ack for the current access.
REQ-007 The block SHALL have port dec_gp_we, dec_mem_wren, dec_mem_rren, dec_illegal  input  1 each  decoder control bits for the instruction in IR.
REQ-008 The block SHALL have port dec_pc_sel  input  2  decoder PC-source select.
REQ-009 The block SHALL have port trap_clr  input  1  pulse; releases TRAP.
REQ-010 The block SHALL have port imem_req, ir_we, dmem_req, dmem_we, gp_we, pc_we  output  1 each  datapath strobes.
REQ-011 The block SHALL have port pc_sel  output  2  latched PC-source select.
REQ-012 The block SHALL have port trap  output  1  sequencer halted on fault.
REQ-013 The block SHALL have port trap_cause  output  2  01 illegal, 10 imem timeout, 11 dmem timeout, 00 none.
REQ-014 The block SHALL have port state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
REQ-015 The block SHALL have port retired  output  32  count of completed instructions.

Function
REQ-016 Outputs SHALL decode from the state register and latched flags (Moore), except ir_we.
REQ-017 IDLE SHALL go to FETCH on the first edge with run=1; otherwise it stays in IDLE.
REQ-018 In FETCH, imem_req=1 SHALL hold until imem_ack=1; ir_we SHALL equal FETCH & imem_ack; on ack the next state SHALL be DECODE.
REQ-019 DECODE SHALL last exactly 1 cycle, latching dec_gp_we, dec_mem_wren, dec_mem_rren and dec_pc_sel; dec_illegal=1 SHALL go to TRAP with cause 01, else EXEC.
REQ-020 EXEC SHALL last exactly 1 cycle; it SHALL go to MEM if latched wren|rren, else WB.
REQ-021 In MEM, dmem_req=1 SHALL hold and dmem_we SHALL equal latched wren until dmem_ack=1, then the next state SHALL be WB.
REQ-022 If latched wren and rren are both 1, the access SHALL be performed as a write (dmem_we=1).
REQ-023 WB SHALL last exactly 1 cycle with pc_we=1, gp_we=latched gp_we and pc_sel=latched select; retired SHALL increment by 1; the next state SHALL be FETCH if run=1, else IDLE.
REQ-024 retired SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-025 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack.
REQ-026 When the wait counter equals MEM_TIMEOUT without ack, the next state SHALL be TRAP with cause 10 (FETCH) or 11 (MEM).
REQ-027 An ack in the same cycle the wait counter reaches MEM_TIMEOUT SHALL win; no trap SHALL be raised.
REQ-028 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes through WB, then the block enters IDLE.
REQ-029 In TRAP, trap=1, all strobes SHALL be 0, and trap_cause SHALL hold; trap_clr=1 SHALL go to IDLE and clear trap_cause to 00.
REQ-030 Acks outside FETCH/MEM SHALL be ignored.
REQ-031 Minimum instruction latency SHALL be 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, WB); with memory access it SHALL be 5 cycles.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, all strobes 0, trap=0, trap_cause=00, retired=0, wait counter=0 and latched flags=0, regardless of clk.
REQ-033 Reset asserted mid-FETCH or mid-MEM SHALL drop imem_req/dmem_req in the same cycle; no partial WB SHALL occur.

Verification
REQ-034 run=1; imem_ack same cycle; decoder ALU op with gp_we=1 -> states 1,2,3,5; gp_we=1 and pc_we=1 in cycle 4; retired=1.
REQ-035 lw: dec_mem_rren=1, dmem_ack after 3 wait cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB; retired increments.
REQ-036 MEM_TIMEOUT=15, imem_ack never asserted -> TRAP after 16 FETCH cycles, trap_cause=10; trap_clr -> IDLE, trap_cause=00.
REQ-037 dec_illegal=1 in DECODE -> TRAP the next cycle, cause 01, no gp_we/pc_we pulse, retired unchanged.
REQ-038 retired preloaded to 0xFFFFFFFF via forced run, one instruction -> retired=0.
REQ-039 rst_n low during MEM with dmem_req=1 -> dmem_req=0 asynchronously; state=0 before the next clk edge.
